// File: rtl/addr4u_residue_check.sv
// Purpose : mod-3 residue checker for a 4-bit adder result, with error count and sticky fault FSM.
// Latency : 2 cycles (S1 capture, S2 check) from the accepting edge to out_valid; 1 triple/cycle.
// Backpr. : valid/ready; stalls hold both stages; in_ready = !s1_vld || !s2_vld || out_ready.
//
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   in_valid/in_ready             operand/sum triple handshake (in_a, in_b, in_sum)
//   out_valid/out_ready           checked result handshake (out_sum, out_err)
//   err_cnt                       saturating count of erroneous results (CNT_W bits)
//   fault_latched, clr_fault      sticky fault indicator and its synchronous clear
module addr4u_residue_check #(
   parameter int CNT_W      = 8,
   parameter int ERR_THRESH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_a,
   input  logic [3:0]       in_b,
   input  logic [4:0]       in_sum,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [4:0]       out_sum,
   output logic             out_err,
   output logic [CNT_W-1:0] err_cnt,
   output logic             fault_latched,
   input  logic             clr_fault
);

   localparam logic [3:0]       THRESH  = 4'(ERR_THRESH);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   typedef enum logic [1:0] {
      ST_OK      = 2'd0,
      ST_SUSPECT = 2'd1,
      ST_FAULT   = 2'd2
   } state_t;

   // x mod 3, MSB-first: r <- (2r + bit) mod 3, never leaving 2 bits.
   function automatic logic [1:0] mod3(input logic [4:0] x);
      logic [2:0] t;
      logic [1:0] r;
      r = 2'd0;
      for (int i = 4; i >= 0; i--) begin
         t = {r, x[i]};
         if (t >= 3'd3) t = t - 3'd3;
         r = t[1:0];
      end
      return r;
   endfunction

   // ---------------- pipeline registers ----------------
   logic       s1_vld_q, s1_vld_d;
   logic [3:0] s1_a_q, s1_a_d;
   logic [3:0] s1_b_q, s1_b_d;
   logic [4:0] s1_sum_q, s1_sum_d;
   logic       s2_vld_q, s2_vld_d;
   logic [4:0] s2_sum_q, s2_sum_d;
   logic       s2_err_q, s2_err_d;
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

   logic       s2_adv, s1_adv;
   logic [1:0] ra, rb, rs;
   logic [2:0] rab;
   logic [1:0] rab_mod;
   logic       hs, hs_err;

   assign s2_adv   = !s2_vld_q || out_ready;
   assign s1_adv   = !s1_vld_q || s2_adv;
   assign in_ready = s1_adv;

   assign ra = mod3({1'b0, s1_a_q});
   assign rb = mod3({1'b0, s1_b_q});
   assign rs = mod3(s1_sum_q);

   // (ra+rb) needs 3 bits (max 4) before a single conditional subtract.
   assign rab     = {1'b0, ra} + {1'b0, rb};
   assign rab_mod = (rab >= 3'd3) ? 2'(rab - 3'd3) : rab[1:0];

   assign hs     = s2_vld_q && out_ready;
   assign hs_err = hs && s2_err_q;

   always_comb begin
      s1_vld_d  = s1_vld_q;
      s1_a_d    = s1_a_q;
      s1_b_d    = s1_b_q;
      s1_sum_d  = s1_sum_q;
      s2_vld_d  = s2_vld_q;
      s2_sum_d  = s2_sum_q;
      s2_err_d  = s2_err_q;
      err_cnt_d = err_cnt_q;

      if (s1_adv) begin
         s1_vld_d = in_valid;
         if (in_valid) begin
            s1_a_d   = in_a;
            s1_b_d   = in_b;
            s1_sum_d = in_sum;
         end
      end

      if (s2_adv) begin
         s2_vld_d = s1_vld_q;
         if (s1_vld_q) begin
            s2_sum_d = s1_sum_q;
            s2_err_d = (rab_mod != rs);
         end
      end

      if (hs_err && (err_cnt_q != CNT_MAX)) err_cnt_d = err_cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_vld_q  <= 1'b0;
         s1_a_q    <= '0;
         s1_b_q    <= '0;
         s1_sum_q  <= '0;
         s2_vld_q  <= 1'b0;
         s2_sum_q  <= '0;
         s2_err_q  <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         s1_vld_q  <= s1_vld_d;
         s1_a_q    <= s1_a_d;
         s1_b_q    <= s1_b_d;
         s1_sum_q  <= s1_sum_d;
         s2_vld_q  <= s2_vld_d;
         s2_sum_q  <= s2_sum_d;
         s2_err_q  <= s2_err_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   // ---------------- fault FSM ----------------
   state_t     state_q;
   logic [3:0] cc_q;
   logic       fault_q;

   // clr_fault wins over a coincident error handshake (err_cnt still counts it).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_OK;
         cc_q    <= 4'd0;
         fault_q <= 1'b0;
      end else if (clr_fault) begin
         state_q <= ST_OK;
         cc_q    <= 4'd0;
         fault_q <= 1'b0;
      end else if (hs) begin
         case (state_q)
            ST_OK: begin
               if (s2_err_q) begin
                  cc_q <= 4'd1;
                  if (THRESH == 4'd1) begin
                     state_q <= ST_FAULT;
                     fault_q <= 1'b1;
                  end else begin
                     state_q <= ST_SUSPECT;
                  end
               end
            end
            ST_SUSPECT: begin
               if (s2_err_q) begin
                  cc_q <= cc_q + 4'd1;
                  if ((cc_q + 4'd1) >= THRESH) begin
                     state_q <= ST_FAULT;
                     fault_q <= 1'b1;
                  end
               end else begin
                  cc_q    <= 4'd0;
                  state_q <= ST_OK;
               end
            end
            default: begin
               // FAULT is sticky; cc is held.
               state_q <= ST_FAULT;
               fault_q <= 1'b1;
            end
         endcase
      end
   end

   assign out_valid     = s2_vld_q;
   assign out_sum       = s2_sum_q;
   assign out_err       = s2_err_q;
   assign err_cnt       = err_cnt_q;
   assign fault_latched = fault_q;

endmodule

// File: tb/tb_addr4u_residue_check.sv
// Purpose : directed bench for addr4u_residue_check (default instance plus CNT_W=2/ERR_THRESH=1 instance).
// Latency : expects results two edges after acceptance with out_ready high.
// Backpr. : exercises an out_ready stall mid-stream and checks order, uniqueness and stability.
module tb_addr4u_residue_check;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   // default instance
   logic       rst_n, in_valid, in_ready, out_valid, out_ready, out_err, fault_latched, clr_fault;
   logic [3:0] in_a, in_b;
   logic [4:0] in_sum, out_sum;
   logic [7:0] err_cnt;

   // small-counter instance
   logic       rst2_n, in2_valid, in2_ready, out2_valid, out2_ready, out2_err, fault2, clr2_fault;
   logic [3:0] in2_a, in2_b;
   logic [4:0] in2_sum, out2_sum;
   logic [1:0] err2_cnt;

   int checks   = 0;
   int failures = 0;

   addr4u_residue_check #(.CNT_W(8), .ERR_THRESH(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_sum(in_sum), .out_valid(out_valid),
      .out_ready(out_ready), .out_sum(out_sum), .out_err(out_err),
      .err_cnt(err_cnt), .fault_latched(fault_latched), .clr_fault(clr_fault)
   );

   addr4u_residue_check #(.CNT_W(2), .ERR_THRESH(1)) dut2 (
      .clk(clk), .rst_n(rst2_n), .in_valid(in2_valid), .in_ready(in2_ready),
      .in_a(in2_a), .in_b(in2_b), .in_sum(in2_sum), .out_valid(out2_valid),
      .out_ready(out2_ready), .out_sum(out2_sum), .out_err(out2_err),
      .err_cnt(err2_cnt), .fault_latched(fault2), .clr_fault(clr2_fault)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Presents one triple, waits for its result and completes the handshake,
   // optionally with clr_fault asserted on the handshake edge.
   task automatic send_one(input logic [3:0] a, input logic [3:0] b, input logic [4:0] s,
                           input logic clr, output logic [4:0] got_sum, output logic got_err);
      int n;
      in_valid = 1'b1; in_a = a; in_b = b; in_sum = s;
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 10) begin
         tick();
         n++;
      end
      checks++;
      if (!out_valid) begin
         failures++;
         $display("FAIL send_one_timeout: out_valid=%0b required=1", out_valid);
      end
      got_sum = out_sum;
      got_err = out_err;
      clr_fault = clr;
      tick();
      clr_fault = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; rst2_n = 1'b0;
      in_valid = 1'b0; in_a = '0; in_b = '0; in_sum = '0; out_ready = 1'b1; clr_fault = 1'b0;
      in2_valid = 1'b0; in2_a = '0; in2_b = '0; in2_sum = '0; out2_ready = 1'b1; clr2_fault = 1'b0;
      tick(); tick();
      checks++;
      if (out_valid !== 1'b0 || out_sum !== 5'd0 || out_err !== 1'b0) begin
         failures++;
         $display("FAIL reset_out: valid=%0b sum=%0d err=%0b required 0/0/0", out_valid, out_sum, out_err);
      end
      checks++;
      if (err_cnt !== 8'd0 || fault_latched !== 1'b0 || dut.cc_q !== 4'd0) begin
         failures++;
         $display("FAIL reset_acct: err_cnt=%0d fault=%0b cc=%0d required 0/0/0", err_cnt, fault_latched, dut.cc_q);
      end
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_in_ready: in_ready=%0b required=1", in_ready);
      end
      rst_n = 1'b1; rst2_n = 1'b1;
      tick();
   endtask

   task automatic test_basic;
      in_valid = 1'b1; in_a = 4'd5; in_b = 4'd6; in_sum = 5'd11; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL basic_latency_early: out_valid=%0b required=0", out_valid);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_sum !== 5'd11 || out_err !== 1'b0) begin
         failures++;
         $display("FAIL basic_result: valid=%0b sum=%0d err=%0b required 1/11/0", out_valid, out_sum, out_err);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0 || err_cnt !== 8'd0) begin
         failures++;
         $display("FAIL basic_drain: valid=%0b err_cnt=%0d required 0/0", out_valid, err_cnt);
      end
   endtask

   task automatic test_error;
      logic [4:0] s; logic e;
      send_one(4'd5, 4'd6, 5'd10, 1'b0, s, e);
      checks++;
      if (s !== 5'd10 || e !== 1'b1 || err_cnt !== 8'd1 || dut.cc_q !== 4'd1 || fault_latched !== 1'b0) begin
         failures++;
         $display("FAIL error_inject: sum=%0d err=%0b cnt=%0d cc=%0d fault=%0b required 10/1/1/1/0", s, e, err_cnt, dut.cc_q, fault_latched);
      end
      send_one(4'd3, 4'd3, 5'd6, 1'b0, s, e);
      checks++;
      if (s !== 5'd6 || e !== 1'b0 || err_cnt !== 8'd1 || dut.cc_q !== 4'd0) begin
         failures++;
         $display("FAIL error_recover: sum=%0d err=%0b cnt=%0d cc=%0d required 6/0/1/0", s, e, err_cnt, dut.cc_q);
      end
   endtask

   task automatic test_undetectable;
      logic [4:0] s; logic e;
      send_one(4'd5, 4'd6, 5'd14, 1'b0, s, e);
      checks++;
      if (s !== 5'd14 || e !== 1'b0 || err_cnt !== 8'd1) begin
         failures++;
         $display("FAIL undetectable: sum=%0d err=%0b cnt=%0d required 14/0/1", s, e, err_cnt);
      end
   endtask

   task automatic test_back_to_back;
      logic [3:0] ta [4] = '{4'd7, 4'd1, 4'd4, 4'd9};
      logic [3:0] tb [4] = '{4'd7, 4'd2, 4'd4, 4'd6};
      logic [4:0] ts [4] = '{5'd13, 5'd3, 5'd8, 5'd15};
      logic       te [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
      int  sent = 0, got = 0;
      logic saw_stall = 1'b0, held = 1'b0;
      logic [4:0] held_sum = '0; logic held_err = 1'b0;
      for (int cyc = 0; cyc < 20; cyc++) begin
         out_ready = (cyc < 2 || cyc > 4);
         if (sent < 4) begin
            in_valid = 1'b1; in_a = ta[sent]; in_b = tb[sent]; in_sum = ts[sent];
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (!in_ready) saw_stall = 1'b1;
         if (held && out_valid) begin
            checks++;
            if (out_sum !== held_sum || out_err !== held_err) begin
               failures++;
               $display("FAIL b2b_stable: sum=%0d err=%0b required %0d/%0b", out_sum, out_err, held_sum, held_err);
            end
         end
         held = out_valid && !out_ready;
         held_sum = out_sum; held_err = out_err;
         if (out_valid && out_ready) begin
            checks++;
            if (got >= 4) begin
               failures++;
               $display("FAIL b2b_extra: result index=%0d required <4", got);
            end else if (out_sum !== ts[got] || out_err !== te[got]) begin
               failures++;
               $display("FAIL b2b_order: idx=%0d sum=%0d err=%0b required %0d/%0b", got, out_sum, out_err, ts[got], te[got]);
            end
            got++;
         end
         if (in_valid && in_ready) sent++;
         tick();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      checks++;
      if (got !== 4) begin
         failures++;
         $display("FAIL b2b_count: results=%0d required=4", got);
      end
      checks++;
      if (saw_stall !== 1'b1) begin
         failures++;
         $display("FAIL b2b_in_ready_drop: saw_drop=%0b required=1", saw_stall);
      end
      checks++;
      if (err_cnt !== 8'd2 || dut.cc_q !== 4'd0) begin
         failures++;
         $display("FAIL b2b_err_cnt: cnt=%0d cc=%0d required 2/0", err_cnt, dut.cc_q);
      end
   endtask

   task automatic test_fault;
      logic [4:0] s; logic e;
      for (int i = 1; i <= 3; i++) begin
         send_one(4'd5, 4'd6, 5'd10, 1'b0, s, e);
         checks++;
         if (fault_latched !== 1'b0 || dut.cc_q !== 4'(i)) begin
            failures++;
            $display("FAIL fault_early_%0d: fault=%0b cc=%0d required 0/%0d", i, fault_latched, dut.cc_q, i);
         end
      end
      send_one(4'd5, 4'd6, 5'd10, 1'b0, s, e);
      checks++;
      if (fault_latched !== 1'b1 || err_cnt !== 8'd6) begin
         failures++;
         $display("FAIL fault_latch: fault=%0b cnt=%0d required 1/6", fault_latched, err_cnt);
      end
      send_one(4'd2, 4'd2, 5'd4, 1'b0, s, e);
      checks++;
      if (fault_latched !== 1'b1 || e !== 1'b0 || err_cnt !== 8'd6) begin
         failures++;
         $display("FAIL fault_sticky: fault=%0b err=%0b cnt=%0d required 1/0/6", fault_latched, e, err_cnt);
      end
      send_one(4'd5, 4'd6, 5'd10, 1'b1, s, e);
      checks++;
      if (fault_latched !== 1'b0 || err_cnt !== 8'd7 || dut.cc_q !== 4'd0 || e !== 1'b1) begin
         failures++;
         $display("FAIL fault_clear: fault=%0b cnt=%0d cc=%0d err=%0b required 0/7/0/1", fault_latched, err_cnt, dut.cc_q, e);
      end
   endtask

   task automatic test_saturation;
      in2_valid = 1'b1; in2_a = 4'd5; in2_b = 4'd6; in2_sum = 5'd10; out2_ready = 1'b1;
      tick(); tick(); tick();
      checks++;
      if (err2_cnt !== 2'd1 || fault2 !== 1'b1) begin
         failures++;
         $display("FAIL sat_first: cnt=%0d fault=%0b required 1/1", err2_cnt, fault2);
      end
      tick(); tick();
      checks++;
      if (err2_cnt !== 2'd3) begin
         failures++;
         $display("FAIL sat_reach: cnt=%0d required=3", err2_cnt);
      end
      tick(); tick();
      checks++;
      if (err2_cnt !== 2'd3 || out2_valid !== 1'b1) begin
         failures++;
         $display("FAIL sat_hold: cnt=%0d valid=%0b required 3/1", err2_cnt, out2_valid);
      end
      rst2_n = 1'b0;
      #1;
      checks++;
      if (out2_valid !== 1'b0 || err2_cnt !== 2'd0 || fault2 !== 1'b0 || in2_ready !== 1'b1) begin
         failures++;
         $display("FAIL async_reset: valid=%0b cnt=%0d fault=%0b in_ready=%0b required 0/0/0/1", out2_valid, err2_cnt, fault2, in2_ready);
      end
      in2_valid = 1'b0;
      tick();
      rst2_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_error();
      test_undetectable();
      test_back_to_back();
      test_fault();
      test_saturation();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
